// File: rtl/fp_pkg.sv
// Shared floating-point definitions for the sequential FP units.
// Contents: IEEE-754 single field constants, canonical special encodings,
// the multiplier FSM state type and the operand class type.
package fp_pkg;

  localparam int SIGN_BIT = 31;
  localparam int EXP_BIAS = 127;
  localparam int EXP_MAX  = 255;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MULT  = 3'd1,
    NORM  = 3'd2,
    ROUND = 3'd3,
    DONE  = 3'd4
  } fp_state_t;

  typedef enum logic [1:0] {
    ZERO   = 2'd0,
    NORMAL = 2'd1,
    INF    = 2'd2,
    NAN    = 2'd3
  } fp_class_t;

endpackage

// File: rtl/fp_classify.sv
// Combinational operand classifier shared by the sequential FP units.
// Ports:
//   op_a, op_b   : IEEE-754 operands
//   cls_a, cls_b : operand class (ZERO covers denormals, which flush to zero)
//   sig_a, sig_b : significand with hidden bit, forced to 0 for a zero exponent
module fp_classify
  import fp_pkg::*;
#(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic [EXP_W+FRAC_W:0] op_a,
  input  logic [EXP_W+FRAC_W:0] op_b,
  output fp_class_t             cls_a,
  output fp_class_t             cls_b,
  output logic [FRAC_W:0]       sig_a,
  output logic [FRAC_W:0]       sig_b
);

  function automatic fp_class_t class_of(input logic [EXP_W-1:0]  exp_f,
                                         input logic [FRAC_W-1:0] frac_f);
    fp_class_t c;
    if (exp_f == {EXP_W{1'b1}}) begin
      if (frac_f != {FRAC_W{1'b0}}) begin
        c = NAN;
      end else begin
        c = INF;
      end
    end else if (exp_f == {EXP_W{1'b0}}) begin
      c = ZERO;
    end else begin
      c = NORMAL;
    end
    return c;
  endfunction

  function automatic logic [FRAC_W:0] sig_of(input logic [EXP_W-1:0]  exp_f,
                                             input logic [FRAC_W-1:0] frac_f);
    logic [FRAC_W:0] s;
    if (exp_f == {EXP_W{1'b0}}) begin
      s = {(FRAC_W+1){1'b0}};
    end else begin
      s = {1'b1, frac_f};
    end
    return s;
  endfunction

  // Classify both operands and extract their significands.
  always_comb begin
    cls_a = class_of(op_a[EXP_W+FRAC_W-1:FRAC_W], op_a[FRAC_W-1:0]);
    cls_b = class_of(op_b[EXP_W+FRAC_W-1:FRAC_W], op_b[FRAC_W-1:0]);
    sig_a = sig_of(op_a[EXP_W+FRAC_W-1:FRAC_W], op_a[FRAC_W-1:0]);
    sig_b = sig_of(op_b[EXP_W+FRAC_W-1:FRAC_W], op_b[FRAC_W-1:0]);
  end

endmodule

// File: rtl/fp_mul_seq.sv
// Multicycle IEEE-754 single-precision multiplier (shift-add, one partial
// product per cycle, fixed 27-cycle busy window, round to nearest even,
// denormals flushed to zero).
// Ports:
//   clk, reset_n : rising-edge clock, synchronous active-low reset
//   start        : request, sampled only while idle (busy=0)
//   opA, opB     : multiplicand / multiplier
//   busy         : high from the cycle after acceptance until done
//   done         : one-cycle pulse when result/flags are valid
//   result       : rounded product, held until the next completion
//   overflow, underflow, invalid : status flags, valid with done, held,
//                  cleared when a new start is accepted
module fp_mul_seq
  import fp_pkg::*;
#(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [EXP_W+FRAC_W:0] opA,
  input  logic [EXP_W+FRAC_W:0] opB,
  output logic                  busy,
  output logic                  done,
  output logic [EXP_W+FRAC_W:0] result,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  invalid
);

  localparam int W  = 1 + EXP_W + FRAC_W;
  localparam int SW = FRAC_W + 1;
  localparam int XW = EXP_W + 2;
  localparam int AW = 2 * SW;

  localparam logic signed [XW-1:0] BIAS_X = XW'(EXP_BIAS);
  localparam logic signed [XW-1:0] MAX_X  = XW'(EXP_MAX);
  localparam logic signed [XW-1:0] ONE_X  = XW'(1);
  localparam logic signed [XW-1:0] ZERO_X = XW'(0);
  localparam logic [4:0]           LAST_CNT = 5'(FRAC_W);

  fp_state_t state_r, state_s;

  fp_class_t       cls_a_s, cls_b_s, cls_a_r, cls_b_r;
  logic [SW-1:0]   sig_a_s, sig_b_s;
  logic [SW-1:0]   mcand_r, mplier_r;
  logic            sign_r;
  logic signed [XW-1:0] exp_r, exp_sum_s, exp_norm_s, exp_rnd_s;
  logic [AW-1:0]   acc_r, acc_next_s;
  logic [SW:0]     partial_s;
  logic [4:0]      cnt_r;

  logic [SW-1:0]   mant_r, mant_norm_s;
  logic            g_r, r_r, s_r, g_s, r_s, s_s;
  logic            rnd_inc_s;
  logic [SW:0]     mant_inc_s;
  logic [FRAC_W-1:0] frac_rnd_s;

  logic [W-1:0]    res_rnd_s, res_pend_r;
  logic            ovf_s, unf_s, inv_s;
  logic            ovf_pend_r, unf_pend_r, inv_pend_r;

  logic            busy_r, done_r, ovf_r, unf_r, inv_r;
  logic [W-1:0]    result_r;

  assign busy      = busy_r;
  assign done      = done_r;
  assign result    = result_r;
  assign overflow  = ovf_r;
  assign underflow = unf_r;
  assign invalid   = inv_r;

  fp_classify #(
    .EXP_W  (EXP_W),
    .FRAC_W (FRAC_W)
  ) u_classify (
    .op_a  (opA),
    .op_b  (opB),
    .cls_a (cls_a_s),
    .cls_b (cls_b_s),
    .sig_a (sig_a_s),
    .sig_b (sig_b_s)
  );

  // Biased exponent sum ea+eb-bias, widened so overflow/underflow stay visible.
  always_comb begin
    exp_sum_s = $signed({2'b00, opA[W-2:FRAC_W]}) + $signed({2'b00, opB[W-2:FRAC_W]}) - BIAS_X;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = MULT;
        end else begin
          state_s = IDLE;
        end
      end
      MULT: begin
        if (cnt_r == LAST_CNT) begin
          state_s = NORM;
        end else begin
          state_s = MULT;
        end
      end
      NORM:    state_s = ROUND;
      ROUND:   state_s = DONE;
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // One shift-add step: conditionally add the multiplicand into the upper
  // half, then shift the whole accumulator right keeping the carry.
  always_comb begin
    if (mplier_r[0]) begin
      partial_s = {1'b0, acc_r[AW-1:SW]} + {1'b0, mcand_r};
    end else begin
      partial_s = {1'b0, acc_r[AW-1:SW]};
    end
    acc_next_s = {partial_s, acc_r[SW-1:1]};
  end

  // Normalisation: the product of two [1,2) significands lies in [1,4).
  always_comb begin
    if (acc_r[AW-1]) begin
      mant_norm_s = acc_r[AW-1:SW];
      g_s         = acc_r[SW-1];
      r_s         = acc_r[SW-2];
      s_s         = |acc_r[SW-3:0];
      exp_norm_s  = exp_r + ONE_X;
    end else begin
      mant_norm_s = acc_r[AW-2:SW-1];
      g_s         = acc_r[SW-2];
      r_s         = acc_r[SW-3];
      s_s         = |acc_r[SW-4:0];
      exp_norm_s  = exp_r;
    end
  end

  // Rounding, range check and special-case override.
  always_comb begin
    rnd_inc_s  = g_r & (r_r | s_r | mant_r[0]);
    mant_inc_s = {1'b0, mant_r} + {{SW{1'b0}}, rnd_inc_s};
    if (mant_inc_s[SW]) begin
      frac_rnd_s = mant_inc_s[SW-1:1];
      exp_rnd_s  = exp_r + ONE_X;
    end else begin
      frac_rnd_s = mant_inc_s[FRAC_W-1:0];
      exp_rnd_s  = exp_r;
    end

    res_rnd_s = {W{1'b0}};
    ovf_s     = 1'b0;
    unf_s     = 1'b0;
    inv_s     = 1'b0;
    if ((cls_a_r == NAN) || (cls_b_r == NAN)) begin
      res_rnd_s = QNAN;
      inv_s     = 1'b1;
    end else if (((cls_a_r == INF) && (cls_b_r == ZERO)) ||
                 ((cls_a_r == ZERO) && (cls_b_r == INF))) begin
      res_rnd_s = QNAN;
      inv_s     = 1'b1;
    end else if ((cls_a_r == INF) || (cls_b_r == INF)) begin
      res_rnd_s = {sign_r, POS_INF[W-2:0]};
    end else if ((cls_a_r == ZERO) || (cls_b_r == ZERO)) begin
      res_rnd_s = {sign_r, {(W-1){1'b0}}};
    end else if (exp_rnd_s >= MAX_X) begin
      res_rnd_s = {sign_r, POS_INF[W-2:0]};
      ovf_s     = 1'b1;
    end else if (exp_rnd_s <= ZERO_X) begin
      res_rnd_s = {sign_r, {(W-1){1'b0}}};
      unf_s     = 1'b1;
    end else begin
      res_rnd_s = {sign_r, exp_rnd_s[EXP_W-1:0], frac_rnd_s};
    end
  end

  // Datapath registers, advanced according to the current state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sign_r     <= 1'b0;
      exp_r      <= ZERO_X;
      mcand_r    <= {SW{1'b0}};
      mplier_r   <= {SW{1'b0}};
      cls_a_r    <= ZERO;
      cls_b_r    <= ZERO;
      acc_r      <= {AW{1'b0}};
      cnt_r      <= 5'd0;
      mant_r     <= {SW{1'b0}};
      g_r        <= 1'b0;
      r_r        <= 1'b0;
      s_r        <= 1'b0;
      res_pend_r <= {W{1'b0}};
      ovf_pend_r <= 1'b0;
      unf_pend_r <= 1'b0;
      inv_pend_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            sign_r   <= opA[W-1] ^ opB[W-1];
            exp_r    <= exp_sum_s;
            mcand_r  <= sig_a_s;
            mplier_r <= sig_b_s;
            cls_a_r  <= cls_a_s;
            cls_b_r  <= cls_b_s;
            acc_r    <= {AW{1'b0}};
            cnt_r    <= 5'd0;
          end
        end
        MULT: begin
          acc_r    <= acc_next_s;
          mplier_r <= mplier_r >> 1;
          cnt_r    <= cnt_r + 5'd1;
        end
        NORM: begin
          mant_r <= mant_norm_s;
          g_r    <= g_s;
          r_r    <= r_s;
          s_r    <= s_s;
          exp_r  <= exp_norm_s;
        end
        ROUND: begin
          res_pend_r <= res_rnd_s;
          ovf_pend_r <= ovf_s;
          unf_pend_r <= unf_s;
          inv_pend_r <= inv_s;
        end
        default: begin
        end
      endcase
    end
  end

  // Registered outputs: busy follows the next state, done marks DONE exit.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      result_r <= {W{1'b0}};
      ovf_r    <= 1'b0;
      unf_r    <= 1'b0;
      inv_r    <= 1'b0;
    end else begin
      busy_r <= (state_s != IDLE);
      done_r <= (state_r == DONE);
      if (state_r == DONE) begin
        result_r <= res_pend_r;
        ovf_r    <= ovf_pend_r;
        unf_r    <= unf_pend_r;
        inv_r    <= inv_pend_r;
      end else if ((state_r == IDLE) && start) begin
        ovf_r <= 1'b0;
        unf_r <= 1'b0;
        inv_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fp_mul_seq.sv
// Self-checking bench for fp_mul_seq: an arithmetic reference model plus a
// per-cycle compare process, and directed vectors with literal expectations.
module tb_fp_mul_seq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [31:0] opA, opB;
  logic        busy, done, overflow, underflow, invalid;
  logic [31:0] result;

  int nvec = 0;
  int nmis = 0;

  always #5 clk = ~clk;

  fp_mul_seq dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .opA       (opA),
    .opB       (opB),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .overflow  (overflow),
    .underflow (underflow),
    .invalid   (invalid)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: exact integer product, then round-to-nearest-even by comparing
  // the discarded remainder against half an ulp. Flags are {ovf, unf, inv}.
  function automatic void model_mul(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic [2:0] f);
    logic s;
    int ea, eb, e, sh;
    longint unsigned ma, mb, p, q, rem, half;
    bit a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    s      = a[31] ^ b[31];
    ea     = int'(a[30:23]);
    eb     = int'(b[30:23]);
    a_nan  = (ea == 255) && (a[22:0] != 23'd0);
    b_nan  = (eb == 255) && (b[22:0] != 23'd0);
    a_inf  = (ea == 255) && (a[22:0] == 23'd0);
    b_inf  = (eb == 255) && (b[22:0] == 23'd0);
    a_zero = (ea == 0);
    b_zero = (eb == 0);
    f = 3'b000;
    r = 32'h0;
    if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) begin
      r = 32'h7FC00000;
      f = 3'b001;
    end else if (a_inf || b_inf) begin
      r = {s, 8'hFF, 23'h0};
    end else if (a_zero || b_zero) begin
      r = {s, 31'h0};
    end else begin
      ma = {40'd0, 1'b1, a[22:0]};
      mb = {40'd0, 1'b1, b[22:0]};
      p  = ma * mb;
      e  = ea + eb - 127;
      if (p >= (64'd1 << 47)) begin
        sh = 24;
        e  = e + 1;
      end else begin
        sh = 23;
      end
      q    = p >> sh;
      rem  = p - (q << sh);
      half = 64'd1 << (sh - 1);
      if ((rem > half) || ((rem == half) && q[0])) q = q + 64'd1;
      if (q == (64'd1 << 24)) begin
        q = q >> 1;
        e = e + 1;
      end
      if (e >= 255) begin
        r = {s, 8'hFF, 23'h0};
        f = 3'b100;
      end else if (e <= 0) begin
        r = {s, 31'h0};
        f = 3'b010;
      end else begin
        r = {s, e[7:0], q[22:0]};
      end
    end
  endfunction

  // Cycle-level expectation: an accepted op completes 27 edges later.
  bit          mv = 1'b0;
  bit          act_m = 1'b0;
  bit          rst_m = 1'b0;
  int          cnt_m = 0;
  logic        busy_m = 1'b0, done_m = 1'b0;
  logic [31:0] res_m = 32'h0, pend_res = 32'h0;
  logic [2:0]  flg_m = 3'b000, pend_flg = 3'b000;

  always @(posedge clk) begin
    if (reset_n === 1'b0) begin
      mv = 1'b1; rst_m = 1'b1; act_m = 1'b0;
      busy_m = 1'b0; done_m = 1'b0; res_m = 32'h0; flg_m = 3'b000;
    end else if (mv) begin
      rst_m  = 1'b0;
      done_m = 1'b0;
      if (act_m) begin
        cnt_m++;
        if (cnt_m == 27) begin
          act_m = 1'b0; busy_m = 1'b0; done_m = 1'b1;
          res_m = pend_res; flg_m = pend_flg;
        end
      end else if (start) begin
        act_m = 1'b1; cnt_m = 0; busy_m = 1'b1; flg_m = 3'b000;
        model_mul(opA, opB, pend_res, pend_flg);
      end
    end
  end

  always @(negedge clk) begin
    if (mv) begin
      check("busy", {31'd0, busy}, {31'd0, busy_m});
      check("done", {31'd0, done}, {31'd0, done_m});
      if (done_m || rst_m) begin
        check("result", result, res_m);
        check("flags", {29'd0, overflow, underflow, invalid}, {29'd0, flg_m});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    opA = a; opB = b; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!done && n < 60);
  endtask

  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input logic [2:0] ef);
    logic [31:0] mr;
    logic [2:0]  mf;
    int n;
    model_mul(a, b, mr, mf);
    check({name, " model result"}, mr, er);
    check({name, " model flags"}, {29'd0, mf}, {29'd0, ef});
    issue(a, b);
    wait_done(n);
    check({name, " latency"}, n, 32'd27);
    check({name, " result"}, result, er);
    check({name, " flags"}, {29'd0, overflow, underflow, invalid}, {29'd0, ef});
    step();
  endtask

  logic [31:0] va [11];
  logic [31:0] vb [11];
  logic [31:0] vr [11];
  logic [2:0]  vf [11];

  initial begin
    int n;
    int pulses;
    va[0]  = 32'h3FC00000; vb[0]  = 32'h40000000; vr[0]  = 32'h40400000; vf[0]  = 3'b000;
    va[1]  = 32'hC0200000; vb[1]  = 32'h40800000; vr[1]  = 32'hC1200000; vf[1]  = 3'b000;
    va[2]  = 32'h3F800001; vb[2]  = 32'h3F800001; vr[2]  = 32'h3F800002; vf[2]  = 3'b000;
    va[3]  = 32'h7F800000; vb[3]  = 32'h00000000; vr[3]  = 32'h7FC00000; vf[3]  = 3'b001;
    va[4]  = 32'h7F800000; vb[4]  = 32'hBF800000; vr[4]  = 32'hFF800000; vf[4]  = 3'b000;
    va[5]  = 32'h7F000000; vb[5]  = 32'h7F000000; vr[5]  = 32'h7F800000; vf[5]  = 3'b100;
    va[6]  = 32'h00800000; vb[6]  = 32'h00800000; vr[6]  = 32'h00000000; vf[6]  = 3'b010;
    va[7]  = 32'h00000001; vb[7]  = 32'h3F800000; vr[7]  = 32'h00000000; vf[7]  = 3'b000;
    va[8]  = 32'h7FC00001; vb[8]  = 32'h3F800000; vr[8]  = 32'h7FC00000; vf[8]  = 3'b001;
    va[9]  = 32'h80000000; vb[9]  = 32'h3F800000; vr[9]  = 32'h80000000; vf[9]  = 3'b000;
    va[10] = 32'h3F800001; vb[10] = 32'h3FC00000; vr[10] = 32'h3FC00002; vf[10] = 3'b000;

    reset_n = 1'b0; start = 1'b0; opA = 32'h0; opB = 32'h0;
    repeat (3) step();
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset result", result, 32'h0);
    reset_n = 1'b1;
    step();

    for (int i = 0; i < 11; i++) begin
      run_op($sformatf("vec%0d", i), va[i], vb[i], vr[i], vf[i]);
    end

    // start re-asserted at edge 10 with other operands must be ignored
    issue(32'h3FC00000, 32'h40000000);
    repeat (9) step();
    opA = 32'h7F800000; opB = 32'h00000000; start = 1'b1;
    step();
    start = 1'b0;
    wait_done(n);
    check("ignored start latency", n, 32'd17);
    check("ignored start result", result, 32'h40400000);
    check("ignored start invalid", {31'd0, invalid}, 32'd0);
    step();

    // start held from the DONE-state cycle: accepted only once busy drops
    issue(32'h3FC00000, 32'h40000000);
    repeat (26) step();
    opA = 32'hC0200000; opB = 32'h40800000; start = 1'b1;
    step();
    check("first op done", {31'd0, done}, 32'd1);
    check("first op result", result, 32'h40400000);
    step();
    start = 1'b0;
    wait_done(n);
    check("b2b latency", n, 32'd27);
    check("b2b result", result, 32'hC1200000);
    step();

    // reset at edge 12 of an operation
    issue(32'h7F000000, 32'h7F000000);
    repeat (11) step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    check("midreset busy", {31'd0, busy}, 32'd0);
    check("midreset done", {31'd0, done}, 32'd0);
    check("midreset result", result, 32'h0);
    check("midreset overflow", {31'd0, overflow}, 32'd0);
    pulses = 0;
    repeat (40) begin
      step();
      if (done) pulses++;
    end
    check("no done after reset", pulses, 32'd0);
    run_op("post reset", 32'h3F800001, 32'h3F800001, 32'h3F800002, 3'b000);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/fp_mul_seq.md
Name: fp_mul_seq

Overview:
- Multicycle IEEE-754 single-precision multiplier that sits directly downstream of the register file, alongside the floating-point coprocessor.
- Consumes the two FP operands read for an FP multiply. Produces a rounded result for the write-back mux.
- Asserts busy so the control path can stall the PC.
- Uses a shift-add mantissa datapath, one partial product per cycle, with a fixed latency.

Parameters:
EXP_W, 8, exponent field width
FRAC_W, 23, fraction field width (significand = FRAC_W+1 bits incl. hidden bit)

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  synchronous active-low reset
start  input  1  request; sampled only when busy=0
opA  input  32  multiplicand, IEEE-754 single
opB  input  32  multiplier, IEEE-754 single
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse when result is valid
result  output  32  product; held until the next accepted start
overflow  output  1  result overflowed to ±inf; valid with done, held
underflow  output  1  result flushed to ±0; valid with done, held
invalid  output  1  inf×0 or NaN operand; valid with done, held

Behaviour:
- Reset (reset_n=0 at a clk edge), including mid-operation: state←IDLE; busy, done, overflow, underflow, invalid ←0; result←32'h0. Any in-flight operation is discarded with no done pulse.
- FSM states: IDLE, MULT, NORM, ROUND, DONE.
- IDLE, start=1:
  - Latch sign = a31^b31 and exponent sum ea+eb-127 (10-bit signed).
  - Latch significands with hidden bit; a zero exponent field forces the significand to 0 (denormals flush to zero).
  - Latch special-case class. Clear the 48-bit product accumulator and the 5-bit counter. Go to MULT; busy←1.
- MULT, 24 cycles:
  - If multiplier LSB is set, add the multiplicand to the accumulator upper half.
  - Shift the accumulator/multiplier right by 1.
  - Counter increments; after count 23, go to NORM.
- NORM: if product bit47=1, shift right 1 and exponent+1. Form guard (G) and round (R) bits; sticky (S) = OR of the remaining low bits.
- ROUND:
  - Round to nearest, ties to even: increment if G & (R | S | lsb).
  - A mantissa carry-out renormalises and increments the exponent.
  - Exponent ≥255 → ±inf, overflow=1. Exponent ≤0 → ±0, underflow=1.
- DONE: result and flags registered; done=1 for exactly this cycle; busy←0; state←IDLE.
- Latency: start sampled at edge 0; done high in the cycle after edge 27; busy high for 27 cycles. The next start can be accepted in the DONE cycle only if busy=0; it is accepted on the following edge.
- Special cases use the same fixed latency; the datapath result is overridden in ROUND:
  - Any NaN operand → 32'h7FC00000, invalid=1.
  - inf×0 → 32'h7FC00000, invalid=1.
  - inf×finite-nonzero → sign|7F800000, no flags.
  - zero (or denormal) × finite → sign|00000000, no flags.
- start while busy=1 is ignored; operands are not re-sampled.
- opA/opB may change freely after acceptance.
- Flags clear when a new start is accepted.

Decomposition:
- Shared package fp_pkg holds:
  - field-position constants: SIGN_BIT, EXP_BIAS=127, EXP_MAX=255
  - canonical QNAN=32'h7FC00000 and POS_INF=32'h7F800000
  - FSM state encoding typedef
  - operand class enum {ZERO, NORMAL, INF, NAN}
- One sub-module: fp_classify (combinational; opA/opB → class + hidden-bit significand). It is shared later with fp_add_seq.

Test Plan:
- Reset, then 0x3FC00000 (1.5) × 0x40000000 (2.0), start=1 for one cycle → busy for 27 cycles; done pulse at edge 27; result=0x40400000; all flags 0.
- 0xC0200000 (-2.5) × 0x40800000 (4.0) → 0xC1200000. Then 0x3F800001 × 0x3F800001 → 0x3F800002 (sticky rounding, no tie increment).
- 0x7F800000 × 0x00000000 → 0x7FC00000, invalid=1. 0x7F800000 × 0xBF800000 → 0xFF800000, invalid=0.
- 0x7F000000 × 0x7F000000 → 0x7F800000, overflow=1. 0x00800000 × 0x00800000 → 0x00000000, underflow=1. Denormal 0x00000001 × 0x3F800000 → 0x00000000.
- start re-asserted at edge 10 with different operands → ignored; first result unchanged. start in the DONE cycle → not accepted until busy=0, second op completes 27 edges later.
- reset_n=0 at edge 12 of an operation → next cycle busy=0, done=0, result=0; no done pulse appears afterwards; a new op then completes normally.
